// File: rtl/dcache_model_pkg.sv
// Shared types and helpers for the data-cache responder model.
// Holds the FSM state encoding, request size codes, the store-log entry
// layout and the big-endian byte-lane merge used when committing stores.
package dcache_model_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dc_state_e;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_WORD2 = 2'b11;

  localparam int LOG_W = 64;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

  // Lane 0 is bits 31:24 (SPARC big-endian). Byte data comes from new_w[7:0],
  // half data from new_w[15:0]; a misaligned half or word aligns down.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [1:0]  size,
                                             input logic [1:0]  addr1_0);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      SZ_BYTE: begin
        mask = 32'hFF00_0000 >> {addr1_0, 3'b000};
        data = {4{new_w[7:0]}};
      end
      SZ_HALF: begin
        mask = addr1_0[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
        data = {2{new_w[15:0]}};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = new_w;
      end
    endcase
    return (old_w & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/dc_store_log_fifo.sv
// Synchronous store-log FIFO. Push while full drops the entry and sets a
// sticky overflow flag; a push and pop together while full both take effect.
// Pop while empty is ignored. Storage is not reset, only pointers and flags.
module dc_store_log_fifo
  import dcache_model_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [LOG_W-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [LOG_W-1:0] o_data,
  output logic             o_ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LOG_W-1:0] r_buf [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [PW:0]      r_cnt;
  logic             r_ovf;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_cnt == (PW+1)'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  assign o_valid = ~w_empty;
  assign o_data  = r_buf[r_rp];
  assign o_ovf   = r_ovf;

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_do_push) r_wp <= (r_wp == PW'(DEPTH-1)) ? '0 : r_wp + 1'b1;
      if (w_do_pop)  r_rp <= (r_rp == PW'(DEPTH-1)) ? '0 : r_rp + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (i_push & w_full & ~w_do_pop) r_ovf <= 1'b1;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (w_do_push) r_buf[r_wp] <= i_data;
  end

endmodule

// File: rtl/dcache_resp_model.sv
// Data-cache responder standing in for a LEON D-cache on the IU data port.
// Loads return the full addressed word after LAT stall cycles; stores merge
// byte lanes into memory and are logged for the verification side to drain.
// Optional macro DC_ERR_INJECT_EN adds err_base/err_mask ports that force a
// memory exception on matching addresses; without it rsp_mexc is always 0.
module dcache_resp_model
  import dcache_model_pkg::*;
#(
  parameter int AW        = 8,
  parameter int LAT       = 2,
  parameter int LOG_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_en,
  input  logic          req_read,
  input  logic          req_write,
  input  logic [31:0]   req_addr,
  input  logic [1:0]    req_size,
  input  logic [31:0]   req_wdata,
  output logic [31:0]   rsp_data,
  output logic          rsp_hold,
  output logic          rsp_mds,
  output logic          rsp_mexc,
  output logic          rsp_werr,
  input  logic          pl_we,
  input  logic [AW-1:0] pl_addr,
  input  logic [31:0]   pl_data,
  output logic          log_valid,
  output logic [31:0]   log_addr,
  output logic [31:0]   log_data,
  input  logic          log_pop,
  output logic          log_ovf
`ifdef DC_ERR_INJECT_EN
  ,
  input  logic [31:0]   err_base,
  input  logic [31:0]   err_mask
`endif
);

  localparam int CW = (LAT < 2) ? 1 : $clog2(LAT);

  dc_state_e     r_state;
  dc_state_e     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_accept;

  logic [31:0]   r_addr;
  logic [1:0]    r_size;
  logic [31:0]   r_wdata;
  logic          r_is_read;
  logic          r_is_write;
  logic          r_fault;

  logic [31:0]   r_mem [0:(1<<AW)-1];

  logic [AW-1:0] w_widx;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_merged;
  logic          w_is_store;
  logic          w_commit;
  logic          w_fault_req;
  log_entry_t    w_push_ent;
  log_entry_t    w_head;

`ifdef DC_ERR_INJECT_EN
  assign w_fault_req = ((req_addr & err_mask) == err_base);
`else
  assign w_fault_req = 1'b0;
`endif

  // Upper address bits beyond the memory are ignored, so addresses wrap.
  assign w_widx     = r_addr[AW+1:2];
  assign w_rd_word  = r_mem[w_widx];
  assign w_merged   = byte_merge(w_rd_word, r_wdata, r_size, r_addr[1:0]);
  assign w_is_store = r_is_write & ~r_is_read;
  // A reset in the response cycle abandons the store entirely.
  assign w_commit   = (r_state == RESP) & w_is_store & ~r_fault & ~rst;

  assign w_push_ent.addr = r_addr;
  assign w_push_ent.data = w_merged;
  assign log_addr        = w_head.addr;
  assign log_data        = w_head.data;

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request capture; only taken when the FSM accepts a new request.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr     <= req_addr;
      r_size     <= req_size;
      r_wdata    <= req_wdata;
      r_is_read  <= req_read;
      r_is_write <= req_write;
      r_fault    <= w_fault_req;
    end
  end

  // Next-state logic and response outputs decoded from the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    rsp_hold    = 1'b1;
    rsp_mds     = 1'b1;
    rsp_mexc    = 1'b0;
    rsp_werr    = 1'b0;
    rsp_data    = 32'h0;
    case (r_state)
      IDLE: begin
        if (req_en && (req_read || req_write)) begin
          w_accept = 1'b1;
          if (LAT == 0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CW'(LAT - 1);
          end
        end
      end
      WAIT: begin
        rsp_hold = 1'b0;
        if (r_cnt == '0) w_state_nxt = RESP;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      RESP: begin
        rsp_mds     = 1'b0;
        rsp_mexc    = r_fault;
        rsp_werr    = r_is_read & r_is_write;
        rsp_data    = (!w_is_store && !r_fault) ? w_rd_word : 32'h0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory writes; the store is last so it wins over a same-word preload.
  always_ff @(posedge clk) begin
    if (pl_we)    r_mem[pl_addr] <= pl_data;
    if (w_commit) r_mem[w_widx]  <= w_merged;
  end

  dc_store_log_fifo #(
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_commit),
    .i_data  (w_push_ent),
    .i_pop   (log_pop),
    .o_valid (log_valid),
    .o_data  (w_head),
    .o_ovf   (log_ovf)
  );

endmodule
